// File: rtl/issue_scheduler_if.sv
// Dispatch, wakeup and issue bundle for issue_scheduler.
// Master drives requests; the scheduler is the slave.
interface issue_scheduler_if #(
    parameter int INST_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int REG_ADDR_WIDTH = 7
);
    logic                           disp_valid;
    logic                           disp_ready;
    logic [INST_WIDTH-1:0]          disp_inst;
    logic [REG_ADDR_WIDTH-1:0]      disp_dst;
    logic [1:0][REG_ADDR_WIDTH-1:0] disp_src;
    logic [1:0]                     disp_src_ready;
    logic                           wb_valid;
    logic [REG_ADDR_WIDTH-1:0]      wb_tag;
    logic                           issue_valid;
    logic                           issue_ready;
    logic [INST_WIDTH-1:0]          issue_inst;
    logic [REG_ADDR_WIDTH-1:0]      issue_dst;
    logic [ADDR_WIDTH-1:0]          issue_slot;
    logic [ADDR_WIDTH:0]            occupancy;

    modport master (
        output disp_valid, disp_inst, disp_dst,
        output disp_src, disp_src_ready,
        output wb_valid, wb_tag, issue_ready,
        input  disp_ready, issue_valid, issue_inst,
        input  issue_dst, issue_slot, occupancy
    );

    modport slave (
        input  disp_valid, disp_inst, disp_dst,
        input  disp_src, disp_src_ready,
        input  wb_valid, wb_tag, issue_ready,
        output disp_ready, issue_valid, issue_inst,
        output issue_dst, issue_slot, occupancy
    );
endinterface

// File: rtl/issue_scheduler.sv
// Wakeup/select scheduler feeding one functional-unit issue port.
// Round-robin select among entries whose two sources are ready.
module issue_scheduler #(
    parameter int INST_WIDTH     = 32,
    parameter int ENTRIES        = 16,
    parameter int ADDR_WIDTH     = $clog2(ENTRIES),
    parameter int PHYS_REG_COUNT = 128,
    parameter int REG_ADDR_WIDTH = $clog2(PHYS_REG_COUNT)
) (
    input logic              clk,
    input logic              sync_rst,
    input logic              clk_en,
    input logic              flush,
    issue_scheduler_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(ENTRIES);

    logic [ENTRIES-1:0]             r_valid;
    logic [INST_WIDTH-1:0]          r_inst [ENTRIES];
    logic [REG_ADDR_WIDTH-1:0]      r_dst  [ENTRIES];
    logic [1:0][REG_ADDR_WIDTH-1:0] r_src  [ENTRIES];
    logic [1:0]                     r_rdy  [ENTRIES];
    logic [ADDR_WIDTH-1:0]          r_rr_ptr;
    logic [ADDR_WIDTH:0]            r_occ;

    logic [ENTRIES-1:0]    w_elig;
    logic [ADDR_WIDTH-1:0] w_free_idx;
    logic [ADDR_WIDTH-1:0] w_win;
    logic                  w_any;
    logic                  w_disp_fire;
    logic                  w_iss_fire;
    logic                  w_wake;
    logic [1:0]            w_byp;

    // Lowest-index free slot from registered state.
    always_comb begin
        w_free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = ADDR_WIDTH'(i);
            end
        end
    end

    // Per-slot eligibility: valid with both sources ready.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            w_elig[i] = r_valid[i] & r_rdy[i][0] & r_rdy[i][1];
        end
    end

    // Rotating search from rr_ptr; the nearest eligible slot wins.
    always_comb begin
        logic [ADDR_WIDTH-1:0] v_idx;
        v_idx = '0;
        w_any = 1'b0;
        w_win = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            v_idx = r_rr_ptr + ADDR_WIDTH'(k);
            if (w_elig[v_idx]) begin
                w_any = 1'b1;
                w_win = v_idx;
            end
        end
    end

    // Source readiness at dispatch, including same-cycle writeback.
    always_comb begin
        w_byp = bus.disp_src_ready;
        for (int j = 0; j < 2; j++) begin
            if (bus.wb_valid && bus.wb_tag == bus.disp_src[j]) begin
                w_byp[j] = 1'b1;
            end
        end
    end

    assign bus.disp_ready  = (r_occ != FULL) & clk_en;
    assign bus.issue_valid = w_any & clk_en;
    assign bus.issue_slot  = w_win;
    assign bus.issue_inst  = w_any ? r_inst[w_win] : '0;
    assign bus.issue_dst   = w_any ? r_dst[w_win] : '0;
    assign bus.occupancy   = r_occ;

    assign w_disp_fire = bus.disp_valid & bus.disp_ready & ~flush;
    assign w_iss_fire  = bus.issue_valid & bus.issue_ready;
    assign w_wake      = bus.wb_valid & clk_en;

    // Slot array: wakeup, issue release, dispatch write, flush.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_inst[i] <= '0;
                r_dst[i]  <= '0;
                r_src[i]  <= '0;
                r_rdy[i]  <= '0;
            end
        end else if (clk_en) begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int j = 0; j < 2; j++) begin
                    if (w_wake && r_valid[i] &&
                        r_src[i][j] == bus.wb_tag) begin
                        r_rdy[i][j] <= 1'b1;
                    end
                end
            end
            if (w_iss_fire) begin
                r_valid[w_win] <= 1'b0;
            end
            if (w_disp_fire) begin
                r_valid[w_free_idx] <= 1'b1;
                r_inst[w_free_idx]  <= bus.disp_inst;
                r_dst[w_free_idx]   <= bus.disp_dst;
                r_src[w_free_idx]   <= bus.disp_src;
                r_rdy[w_free_idx]   <= w_byp;
            end
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    // Round-robin pointer moves past the slot just issued.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_rr_ptr <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_rr_ptr <= '0;
            end else if (w_iss_fire) begin
                r_rr_ptr <= w_win + 1'b1;
            end
        end
    end

    // Occupancy tracks accepted dispatches minus issues.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_occ <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_occ <= '0;
            end else begin
                r_occ <= r_occ + (ADDR_WIDTH+1)'(w_disp_fire)
                               - (ADDR_WIDTH+1)'(w_iss_fire);
            end
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed testbench for issue_scheduler.
// Checks dispatch, wakeup, round-robin select, flush, clk_en, reset.
module tb_issue_scheduler;
    logic clk = 1'b0;
    logic sync_rst;
    logic clk_en;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;

    issue_scheduler_if #(
        .INST_WIDTH(32), .ADDR_WIDTH(4), .REG_ADDR_WIDTH(7)
    ) bus_if ();

    issue_scheduler #(
        .INST_WIDTH(32), .ENTRIES(16), .PHYS_REG_COUNT(128)
    ) dut (
        .clk(clk),
        .sync_rst(sync_rst),
        .clk_en(clk_en),
        .flush(flush),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic [31:0] inst, input logic [6:0] dst,
                        input logic [6:0] s0, input logic [6:0] s1,
                        input logic [1:0] rdy);
        bus_if.disp_valid     = 1'b1;
        bus_if.disp_inst      = inst;
        bus_if.disp_dst       = dst;
        bus_if.disp_src[0]    = s0;
        bus_if.disp_src[1]    = s1;
        bus_if.disp_src_ready = rdy;
    endtask

    initial begin
        sync_rst = 1'b1;
        clk_en   = 1'b1;
        flush    = 1'b0;
        bus_if.disp_valid     = 1'b0;
        bus_if.disp_inst      = '0;
        bus_if.disp_dst       = '0;
        bus_if.disp_src       = '0;
        bus_if.disp_src_ready = '0;
        bus_if.wb_valid       = 1'b0;
        bus_if.wb_tag         = '0;
        bus_if.issue_ready    = 1'b0;
        tick();
        tick();
        sync_rst = 1'b0;
        chk("rst_occ", 64'(bus_if.occupancy), 0);
        chk("rst_dready", 64'(bus_if.disp_ready), 1);
        chk("rst_ivalid", 64'(bus_if.issue_valid), 0);
        chk("rst_slot", 64'(bus_if.issue_slot), 0);

        // three ready entries, held
        for (int i = 0; i < 3; i++) begin
            disp(32'(100 + i), 7'(i + 1), 7'd0, 7'd0, 2'b11);
            tick();
        end
        bus_if.disp_valid = 1'b0;
        chk("fill3_occ", 64'(bus_if.occupancy), 3);
        chk("fill3_iv", 64'(bus_if.issue_valid), 1);
        chk("fill3_slot", 64'(bus_if.issue_slot), 0);
        chk("fill3_inst", 64'(bus_if.issue_inst), 100);
        chk("fill3_dst", 64'(bus_if.issue_dst), 1);
        bus_if.issue_ready = 1'b1;
        tick();
        chk("ord_slot1", 64'(bus_if.issue_slot), 1);
        chk("ord_inst1", 64'(bus_if.issue_inst), 101);
        chk("ord_occ2", 64'(bus_if.occupancy), 2);
        tick();
        chk("ord_slot2", 64'(bus_if.issue_slot), 2);
        chk("ord_occ1", 64'(bus_if.occupancy), 1);
        tick();
        chk("ord_empty_iv", 64'(bus_if.issue_valid), 0);
        chk("ord_empty_occ", 64'(bus_if.occupancy), 0);
        bus_if.issue_ready = 1'b0;

        // wakeup: src=(5,9) not ready
        disp(32'd200, 7'd50, 7'd5, 7'd9, 2'b00);
        tick();
        bus_if.disp_valid = 1'b0;
        chk("wk_occ", 64'(bus_if.occupancy), 1);
        chk("wk_iv0", 64'(bus_if.issue_valid), 0);
        bus_if.wb_valid = 1'b1;
        bus_if.wb_tag   = 7'd5;
        tick();
        chk("wk_iv_after5", 64'(bus_if.issue_valid), 0);
        bus_if.wb_tag = 7'd9;
        tick();
        bus_if.wb_valid = 1'b0;
        chk("wk_iv_after9", 64'(bus_if.issue_valid), 1);
        chk("wk_inst", 64'(bus_if.issue_inst), 200);
        chk("wk_slot", 64'(bus_if.issue_slot), 0);
        bus_if.issue_ready = 1'b1;
        tick();
        bus_if.issue_ready = 1'b0;

        // same-cycle bypass on dispatch
        disp(32'd300, 7'd51, 7'd7, 7'd7, 2'b00);
        bus_if.wb_valid = 1'b1;
        bus_if.wb_tag   = 7'd7;
        tick();
        bus_if.disp_valid = 1'b0;
        bus_if.wb_valid   = 1'b0;
        chk("byp_iv", 64'(bus_if.issue_valid), 1);
        chk("byp_inst", 64'(bus_if.issue_inst), 300);
        bus_if.issue_ready = 1'b1;
        tick();
        bus_if.issue_ready = 1'b0;
        chk("byp_occ0", 64'(bus_if.occupancy), 0);

        // fill all 16 slots, each waiting on tag 20+i
        for (int i = 0; i < 16; i++) begin
            disp(32'(400 + i), 7'(i), 7'(20 + i), 7'(20 + i), 2'b00);
            tick();
        end
        chk("full_occ", 64'(bus_if.occupancy), 16);
        chk("full_dready", 64'(bus_if.disp_ready), 0);
        disp(32'd500, 7'd60, 7'd0, 7'd0, 2'b11);
        bus_if.wb_valid = 1'b1;
        bus_if.wb_tag   = 7'd24;
        tick();
        bus_if.wb_valid = 1'b0;
        chk("full_occ_hold", 64'(bus_if.occupancy), 16);
        chk("full_iv", 64'(bus_if.issue_valid), 1);
        chk("full_slot4", 64'(bus_if.issue_slot), 4);
        chk("full_inst4", 64'(bus_if.issue_inst), 404);
        bus_if.issue_ready = 1'b1;
        tick();
        bus_if.issue_ready = 1'b0;
        chk("free_dready", 64'(bus_if.disp_ready), 1);
        chk("free_occ", 64'(bus_if.occupancy), 15);
        chk("free_iv", 64'(bus_if.issue_valid), 0);
        tick();
        bus_if.disp_valid = 1'b0;
        chk("refill_occ", 64'(bus_if.occupancy), 16);
        chk("refill_slot", 64'(bus_if.issue_slot), 4);
        chk("refill_inst", 64'(bus_if.issue_inst), 500);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush16_occ", 64'(bus_if.occupancy), 0);

        // round-robin: slots 0, 3, 10 ready
        for (int i = 0; i < 11; i++) begin
            if (i == 0 || i == 3 || i == 10) begin
                disp(32'(600 + i), 7'(i), 7'd0, 7'd0, 2'b11);
            end else begin
                disp(32'(600 + i), 7'(i), 7'(40 + i), 7'(40 + i), 2'b00);
            end
            tick();
        end
        bus_if.disp_valid = 1'b0;
        chk("rr_first", 64'(bus_if.issue_slot), 0);
        bus_if.issue_ready = 1'b1;
        tick();
        chk("rr_second", 64'(bus_if.issue_slot), 3);
        tick();
        chk("rr_third", 64'(bus_if.issue_slot), 10);
        tick();
        bus_if.issue_ready = 1'b0;
        chk("rr_none_iv", 64'(bus_if.issue_valid), 0);
        chk("rr_occ", 64'(bus_if.occupancy), 8);
        bus_if.wb_valid = 1'b1;
        bus_if.wb_tag   = 7'd41;
        tick();
        bus_if.wb_valid = 1'b0;
        chk("rr_wrap_iv", 64'(bus_if.issue_valid), 1);
        chk("rr_wrap_slot", 64'(bus_if.issue_slot), 1);
        chk("rr_wrap_inst", 64'(bus_if.issue_inst), 601);

        // flush with 5 entries and concurrent dispatch
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            disp(32'(700 + i), 7'(i), 7'd0, 7'd0, 2'b11);
            tick();
        end
        chk("fl5_occ", 64'(bus_if.occupancy), 5);
        disp(32'd777, 7'd77, 7'd0, 7'd0, 2'b11);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus_if.disp_valid = 1'b0;
        chk("fl_occ0", 64'(bus_if.occupancy), 0);
        chk("fl_iv0", 64'(bus_if.issue_valid), 0);
        tick();
        chk("fl_absent_occ", 64'(bus_if.occupancy), 0);
        chk("fl_absent_iv", 64'(bus_if.issue_valid), 0);

        // clk_en low for three cycles
        disp(32'd800, 7'd1, 7'd0, 7'd0, 2'b11);
        tick();
        disp(32'd801, 7'd2, 7'd0, 7'd0, 2'b11);
        tick();
        chk("ce_pre_occ", 64'(bus_if.occupancy), 2);
        clk_en = 1'b0;
        bus_if.issue_ready = 1'b1;
        bus_if.wb_valid    = 1'b1;
        bus_if.wb_tag      = 7'd3;
        #1;
        chk("ce_iv0", 64'(bus_if.issue_valid), 0);
        chk("ce_dready0", 64'(bus_if.disp_ready), 0);
        tick();
        tick();
        tick();
        chk("ce_occ_hold", 64'(bus_if.occupancy), 2);
        chk("ce_iv_hold", 64'(bus_if.issue_valid), 0);
        bus_if.disp_valid  = 1'b0;
        bus_if.issue_ready = 1'b0;
        bus_if.wb_valid    = 1'b0;
        clk_en = 1'b1;
        #1;
        chk("ce_back_iv", 64'(bus_if.issue_valid), 1);
        chk("ce_back_slot", 64'(bus_if.issue_slot), 0);
        chk("ce_back_inst", 64'(bus_if.issue_inst), 800);

        // sync reset mid-traffic
        bus_if.issue_ready = 1'b1;
        tick();
        chk("sr_pre_slot", 64'(bus_if.issue_slot), 1);
        disp(32'd900, 7'd9, 7'd0, 7'd0, 2'b11);
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        bus_if.disp_valid  = 1'b0;
        bus_if.issue_ready = 1'b0;
        chk("sr_occ", 64'(bus_if.occupancy), 0);
        chk("sr_iv", 64'(bus_if.issue_valid), 0);
        chk("sr_slot", 64'(bus_if.issue_slot), 0);
        disp(32'd910, 7'd1, 7'd0, 7'd0, 2'b11);
        tick();
        disp(32'd911, 7'd2, 7'd0, 7'd0, 2'b11);
        tick();
        bus_if.disp_valid = 1'b0;
        chk("sr_rr_slot", 64'(bus_if.issue_slot), 0);
        chk("sr_rr_inst", 64'(bus_if.issue_inst), 910);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Wakeup/select scheduler in front of a single functional-unit issue port. It holds renamed instructions in a small slot array and tracks per-source-operand readiness against physical-register writeback broadcasts. Each cycle it selects one fully-ready entry, using round-robin priority, for issue to the functional unit. It sits between rename/dispatch and the execution unit and sequences how the shared issue port is used.

## Interface
Parameters:
- INST_WIDTH, 32, opaque instruction payload width
- ENTRIES, 16, scheduler slots; must be a power of two, ≥2
- ADDR_WIDTH, $clog2(ENTRIES), slot index width
- PHYS_REG_COUNT, 128, physical register count
- REG_ADDR_WIDTH, $clog2(PHYS_REG_COUNT), physical tag width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- sync_rst  in  1  synchronous reset, active-high
- clk_en  in  1  state-update enable
- flush  in  1  discard all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free slot exists
- disp_inst  in  INST_WIDTH  payload
- disp_dst  in  REG_ADDR_WIDTH  destination physical tag
- disp_src  in  [1:0][REG_ADDR_WIDTH]  source physical tags
- disp_src_ready  in  [1:0]  source already available at dispatch
- wb_valid  in  1  writeback broadcast valid
- wb_tag  in  REG_ADDR_WIDTH  tag being written back
- issue_valid  out  1  selected entry presented
- issue_ready  in  1  functional unit accepts
- issue_inst  out  INST_WIDTH  selected payload
- issue_dst  out  REG_ADDR_WIDTH  selected destination tag
- issue_slot  out  ADDR_WIDTH  selected slot index
- occupancy  out  ADDR_WIDTH+1  count of valid slots

## Operation
- Per-slot state: valid, inst, dst, src[1:0], rdy[1:0].
- Dispatch:
  - Accepted when disp_valid && disp_ready && clk_en && !flush.
  - The entry is written to the lowest-index slot that is free in the current registered state.
  - rdy[i] is set to disp_src_ready[i], OR'd with (wb_valid && wb_tag == disp_src[i]). This same-cycle bypass is mandatory.
- Wakeup:
  - When wb_valid && clk_en, every valid slot with src[i] == wb_tag sets rdy[i].
  - Already-set bits stay set.
- Select:
  - An entry is eligible when valid && rdy[0] && rdy[1].
  - The search starts at rr_ptr and ascends, wrapping modulo ENTRIES; the first eligible slot wins.
  - Select is combinational from registered state.
  - issue_valid = any eligible && clk_en.
  - issue_inst, issue_dst and issue_slot reflect the winner; when issue_valid=0 they are don't-care but must hold a stable value.
- Issue handshake (issue_valid && issue_ready): the winning slot's valid clears, and rr_ptr <= (issue_slot+1) mod ENTRIES.
- rr_ptr changes only on a handshake.
- disp_ready = (occupancy != ENTRIES) && clk_en; it is computed from registered state only.
- Simultaneous events:
  - Dispatch and issue in the same cycle: both take effect. The slot freed by issue is not reusable until the next cycle. Occupancy is unchanged.
  - Wakeup and issue in the same cycle: the issued entry's wakeup is irrelevant; other slots update normally.
  - A dispatched entry is never eligible in its own dispatch cycle.
- flush: all valid bits clear next cycle. It overrides any same-cycle dispatch; an issue handshake in that cycle is still honoured by the FU. rr_ptr resets to 0.
- clk_en=0: no state changes. disp_ready=0 and issue_valid=0. wb broadcasts in that cycle are lost, and the producer must not broadcast then.
- Reset values: all valid=0, rdy=0, rr_ptr=0. Outputs after reset: disp_ready=1 (once clk_en=1), issue_valid=0, occupancy=0, issue_slot=0.

## Timing
- Dispatch at edge t → entry visible (occupancy++) in cycle t+1. It may issue in t+1 if ready.
- Wakeup at cycle t → the dependent entry is eligible in cycle t+1 (1-cycle wakeup-to-select).
- Issue handshake at cycle t → slot free and occupancy-- in t+1.
- No output depends combinationally on disp_* or wb_*. issue_valid depends on clk_en only.
- sync_rst asserted mid-operation: everything returns to reset values at the next edge. In-flight handshakes in that cycle are discarded.
- occupancy arithmetic is ADDR_WIDTH+1 bits, so ENTRIES is representable. It is never decremented below 0 or incremented beyond ENTRIES.

## Test plan
- Reset, then dispatch 3 entries with both disp_src_ready=1, holding issue_ready=0 → slots 0,1,2 filled, occupancy=3, issue_slot=0. Then raise issue_ready → issue order is slots 0,1,2, one per cycle.
- Dispatch an entry with src=(5,9), ready=(0,0), then wb_tag=5, then wb_tag=9 → issue_valid rises exactly one cycle after the wb_tag=9 broadcast. Also dispatch with src=7 in the same cycle as wb_tag=7 → entry enters ready.
- Fill all 16 slots → disp_ready=0 and occupancy=16. Issue slot 4 while disp_valid is held → disp_ready=1 next cycle, and the new entry lands in slot 4.
- Round-robin: slots 0, 3 and 10 are ready. Issue slot 0 → rr_ptr=1 and the next grant is 3, then 10. Then make slot 1 ready → it wins after wrap.
- flush with 5 entries present and a concurrent dispatch → occupancy=0 next cycle, issue_valid=0, and the dispatched entry is absent.
- clk_en=0 for 3 cycles with entries ready → issue_valid=0 and disp_ready=0, state unchanged. sync_rst mid-traffic → occupancy=0 and rr_ptr=0 next cycle.
